// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads byte-wide program memory, assembles one- or two-byte
// instructions and hands them to decode under a valid/stall handshake.
module instr_fetch_unit #(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    output logic          imem_rd,
    input  logic [7:0]    imem_data,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          stall,
    output logic          ir_valid,
    output logic [7:0]    ir_opcode,
    output logic [7:0]    ir_operand,
    output logic [AW-1:0] ir_pc,
    output logic          ir_len2
);

    typedef enum logic [1:0] {
        ISSUE_OP = 2'd0,
        WAIT_OP  = 2'd1,
        WAIT_OD  = 2'd2,
        PRESENT  = 2'd3
    } state_t;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PC_TWO = {{(AW-2){1'b0}}, 2'b10};

    state_t        state_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_plus1_s;
    logic [AW-1:0] pc_next_s;
    logic          op_two_s;

    // Opcodes that carry an operand byte; everything else is a single byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        logic two;
        case (op[7:3])
            5'b00001, 5'b00110, 5'b01011, 5'b10001, 5'b10011,
            5'b10101, 5'b10111, 5'b11001, 5'b11011, 5'b11101: two = 1'b1;
            5'b00000: two = (op[2:0] == 3'd3) || (op[2:0] == 3'd5);
            default:  two = 1'b0;
        endcase
        return two;
    endfunction

    // Address arithmetic and opcode length classification.
    always_comb begin
        pc_plus1_s = pc_r + PC_ONE;
        pc_next_s  = pc_r + (ir_len2 ? PC_TWO : PC_ONE);
        op_two_s   = is_two_byte(imem_data);
    end

    // Memory read strobe and address, decoded from current state and pc.
    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = pc_r;
        if (reset) begin
            imem_rd   = 1'b0;
            imem_addr = pc_r;
        end else begin
            case (state_r)
                ISSUE_OP: begin
                    imem_rd   = 1'b1;
                    imem_addr = pc_r;
                end
                WAIT_OP: begin
                    if (op_two_s) begin
                        imem_rd   = 1'b1;
                        imem_addr = pc_plus1_s;
                    end else begin
                        imem_rd   = 1'b0;
                        imem_addr = pc_r;
                    end
                end
                WAIT_OD: begin
                    imem_rd   = 1'b0;
                    imem_addr = pc_r;
                end
                PRESENT: begin
                    if (stall) begin
                        imem_rd   = 1'b0;
                        imem_addr = pc_r;
                    end else begin
                        imem_rd   = 1'b1;
                        imem_addr = pc_next_s;
                    end
                end
                default: begin
                    imem_rd   = 1'b0;
                    imem_addr = pc_r;
                end
            endcase
        end
    end

    // Fetch FSM; a redirect simply abandons any read in flight because
    // ISSUE_OP never captures imem_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ISSUE_OP;
            pc_r       <= RESET_PC;
            ir_valid   <= 1'b0;
            ir_opcode  <= 8'h00;
            ir_operand <= 8'h00;
            ir_pc      <= RESET_PC;
            ir_len2    <= 1'b0;
        end else if (redirect) begin
            state_r  <= ISSUE_OP;
            pc_r     <= redirect_pc;
            ir_valid <= 1'b0;
        end else begin
            case (state_r)
                ISSUE_OP: begin
                    state_r <= WAIT_OP;
                end
                WAIT_OP: begin
                    ir_opcode <= imem_data;
                    ir_pc     <= pc_r;
                    ir_len2   <= op_two_s;
                    if (op_two_s) begin
                        state_r <= WAIT_OD;
                    end else begin
                        ir_operand <= 8'h00;
                        ir_valid   <= 1'b1;
                        state_r    <= PRESENT;
                    end
                end
                WAIT_OD: begin
                    ir_operand <= imem_data;
                    ir_valid   <= 1'b1;
                    state_r    <= PRESENT;
                end
                PRESENT: begin
                    if (!stall) begin
                        pc_r     <= pc_next_s;
                        ir_valid <= 1'b0;
                        state_r  <= WAIT_OP;
                    end
                end
                default: begin
                    state_r  <= ISSUE_OP;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle-by-cycle expectations against a
// one-cycle-latency byte memory model.
module tb_instr_fetch_unit;

    logic       clk;
    logic       reset;
    logic [7:0] imem_addr;
    logic       imem_rd;
    logic [7:0] imem_data;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       stall;
    logic       ir_valid;
    logic [7:0] ir_opcode;
    logic [7:0] ir_operand;
    logic [7:0] ir_pc;
    logic       ir_len2;

    logic [7:0] mem [0:255];
    logic [7:0] addr_log [$];
    int         tests;
    int         fails;
    int         xfer_40;

    instr_fetch_unit #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .ir_valid(ir_valid), .ir_opcode(ir_opcode), .ir_operand(ir_operand),
        .ir_pc(ir_pc), .ir_len2(ir_len2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory: data returned the cycle after the strobe.
    always @(posedge clk) begin
        if (imem_rd) begin
            imem_data <= mem[imem_addr];
            addr_log.push_back(imem_addr);
        end
    end

    // Count transfers of the instruction at 0x40 to prove single hand-off.
    always @(posedge clk) begin
        if (!reset && ir_valid && !stall && ir_pc == 8'h40) xfer_40 = xfer_40 + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic v, input logic [7:0] op,
                          input logic [7:0] od, input logic [7:0] pc, input logic l2);
        chk({tag, ".valid"},   {31'd0, ir_valid}, {31'd0, v});
        chk({tag, ".opcode"},  {24'd0, ir_opcode}, {24'd0, op});
        chk({tag, ".operand"}, {24'd0, ir_operand}, {24'd0, od});
        chk({tag, ".pc"},      {24'd0, ir_pc}, {24'd0, pc});
        chk({tag, ".len2"},    {31'd0, ir_len2}, {31'd0, l2});
    endtask

    task automatic chk_rd(input string tag, input logic rd, input logic [7:0] addr);
        chk({tag, ".rd"}, {31'd0, imem_rd}, {31'd0, rd});
        if (rd) chk({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, addr});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; xfer_40 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h00; mem[8'h01] = 8'h41; mem[8'h02] = 8'h5A; mem[8'h03] = 8'h7F;
        mem[8'h04] = 8'h3C; mem[8'h05] = 8'h88; mem[8'h06] = 8'h12; mem[8'h07] = 8'h0A;
        mem[8'h08] = 8'h55; mem[8'h40] = 8'hC9; mem[8'h41] = 8'h66; mem[8'h42] = 8'h77;
        mem[8'hFF] = 8'h03;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

        cyc(); cyc();
        chk_ir("rst", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("rst.rd", {31'd0, imem_rd}, 32'd0);

        // Sequential fetch: NOP, INC, MVI 0x7F
        reset = 1'b0; #1;
        chk_rd("c0", 1'b1, 8'h00);
        chk("c0.valid", {31'd0, ir_valid}, 32'd0);
        cyc(); #1; chk("c1.valid", {31'd0, ir_valid}, 32'd0); chk_rd("c1", 1'b0, 8'h00);
        cyc(); #1; chk_ir("c2", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0); chk_rd("c2", 1'b1, 8'h01);
        cyc(); #1; chk("c3.valid", {31'd0, ir_valid}, 32'd0);
        cyc(); #1; chk_ir("c4", 1'b1, 8'h41, 8'h00, 8'h01, 1'b0); chk_rd("c4", 1'b1, 8'h02);
        cyc(); #1; chk_rd("c5", 1'b1, 8'h03);
        cyc(); #1; chk("c6.valid", {31'd0, ir_valid}, 32'd0);
        cyc(); #1; chk_ir("c7", 1'b1, 8'h5A, 8'h7F, 8'h02, 1'b1); chk_rd("c7", 1'b1, 8'h04);
        cyc(); #1;
        cyc(); #1; chk_ir("c9", 1'b1, 8'h3C, 8'h00, 8'h04, 1'b0);
        chk("log.size", addr_log.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < addr_log.size()) chk("log.addr", {24'd0, addr_log[i]}, i);
        end

        // Two-byte 0x88 held under a 4-cycle stall
        cyc(); #1;
        cyc(); #1;
        cyc(); stall = 1'b1; #1;
        chk_ir("stall0", 1'b1, 8'h88, 8'h12, 8'h05, 1'b1); chk_rd("stall0", 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk_ir("stall", 1'b1, 8'h88, 8'h12, 8'h05, 1'b1); chk_rd("stall", 1'b0, 8'h00);
        end
        cyc(); stall = 1'b0; #1;
        chk("rel.valid", {31'd0, ir_valid}, 32'd1); chk_rd("rel", 1'b1, 8'h07);

        // Redirect during WAIT_OD of 0x0A @7
        cyc(); #1; chk_rd("c17", 1'b1, 8'h08);
        cyc(); redirect = 1'b1; redirect_pc = 8'h40; #1;
        chk("c18.valid", {31'd0, ir_valid}, 32'd0);
        cyc(); redirect = 1'b0; #1;
        chk("c19.valid", {31'd0, ir_valid}, 32'd0); chk_rd("c19", 1'b1, 8'h40);
        chk("c19.operand", {24'd0, ir_operand}, 32'h12);
        cyc(); #1;
        chk("c20.valid", {31'd0, ir_valid}, 32'd0);
        chk("c20.operand", {24'd0, ir_operand}, 32'h12);
        cyc(); #1;

        // Redirect coinciding with a consume of 0xC9 @0x40
        cyc(); redirect = 1'b1; redirect_pc = 8'hFF; #1;
        chk_ir("c22", 1'b1, 8'hC9, 8'h66, 8'h40, 1'b1); chk_rd("c22", 1'b1, 8'h42);
        cyc(); redirect = 1'b0; mem[8'h00] = 8'hA5; #1;
        chk("c23.valid", {31'd0, ir_valid}, 32'd0); chk_rd("c23", 1'b1, 8'hFF);
        chk("c23.xfer40", xfer_40, 32'd1);

        // Two-byte opcode at top address wraps operand fetch to 0x00
        cyc(); #1; chk_rd("c24", 1'b1, 8'h00);
        cyc(); #1; chk("c25.opcode", {24'd0, ir_opcode}, 32'h03);
        chk("c25.valid", {31'd0, ir_valid}, 32'd0);
        cyc(); #1; chk_ir("c26", 1'b1, 8'h03, 8'hA5, 8'hFF, 1'b1); chk_rd("c26", 1'b1, 8'h01);
        cyc(); #1;
        cyc(); stall = 1'b1; #1;
        chk_ir("c28", 1'b1, 8'h41, 8'h00, 8'h01, 1'b0);

        // Reset while stalled in PRESENT
        cyc(); reset = 1'b1; #1;
        chk_ir("c29", 1'b1, 8'h41, 8'h00, 8'h01, 1'b0); chk_rd("c29", 1'b0, 8'h00);
        cyc(); reset = 1'b0; stall = 1'b0; #1;
        chk_ir("c30", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0); chk_rd("c30", 1'b1, 8'h00);
        cyc(); #1;
        cyc(); #1; chk_ir("c32", 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0);
        chk("end.xfer40", xfer_40, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
